// File: rtl/sdram_pll_reset_seq.sv
// sdram_pll_reset_seq: syncs PLL lock and releases SDRAM, core and camera resets in order
module sdram_pll_reset_seq #(
  parameter int SYNC_STAGES     = 2,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int SDRAM_PWRUP_CYC = 20000,
  parameter int CAM_DELAY_CYC   = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       sdram_rst,
  output logic       core_rst,
  output logic       cam_rst,
  output logic       ready,
  output logic [7:0] lock_loss_cnt
);
  localparam int MAX_CYC = (LOCK_STABLE_CYC > SDRAM_PWRUP_CYC) ?
    ((LOCK_STABLE_CYC > CAM_DELAY_CYC) ? LOCK_STABLE_CYC : CAM_DELAY_CYC) :
    ((SDRAM_PWRUP_CYC > CAM_DELAY_CYC) ? SDRAM_PWRUP_CYC : CAM_DELAY_CYC);
  localparam int CW = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] T_STABLE = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] T_PWRUP  = CW'(SDRAM_PWRUP_CYC - 1);
  localparam logic [CW-1:0] T_CAM    = CW'(CAM_DELAY_CYC - 1);
  typedef enum logic [2:0] {WAIT_LOCK, STABLE, PWRUP, CAM_WAIT, RUN} state_t;
  state_t state, nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic lock_s, lost, tc;
  assign lock_s = sync[SYNC_STAGES-1];
  always_comb begin
    lost = !lock_s && state != WAIT_LOCK;
    tc = state == STABLE   ? cnt == T_STABLE :
         state == PWRUP    ? cnt == T_PWRUP  :
         state == CAM_WAIT ? cnt == T_CAM    : 1'b0;
    nxt = lost                ? WAIT_LOCK :
          state == WAIT_LOCK  ? (lock_s ? STABLE : WAIT_LOCK) :
          !tc                 ? state :
          state == STABLE     ? PWRUP :
          state == PWRUP      ? CAM_WAIT : RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync          <= '0;
      state         <= WAIT_LOCK;
      cnt           <= '0;
      lock_loss_cnt <= '0;
      sdram_rst     <= 1'b1;
      core_rst      <= 1'b1;
      cam_rst       <= 1'b1;
      ready         <= 1'b0;
    end else begin
      sync          <= {sync[SYNC_STAGES-2:0], locked};
      state         <= nxt;
      cnt           <= (nxt != state || state == WAIT_LOCK || state == RUN) ? '0 : cnt + 1'b1;
      lock_loss_cnt <= lock_loss_cnt + {7'd0, lost && lock_loss_cnt != 8'hff};
      sdram_rst     <= nxt == WAIT_LOCK || nxt == STABLE;
      core_rst      <= nxt == WAIT_LOCK || nxt == STABLE || nxt == PWRUP;
      cam_rst       <= nxt != RUN;
      ready         <= nxt == RUN;
    end
  end
endmodule

// File: tb/tb_sdram_pll_reset_seq.sv
// tb_sdram_pll_reset_seq: table vectors, corner sequences and random lock activity vs a lock-age model
module tb_sdram_pll_reset_seq;
  localparam int S  = 2;
  localparam int LS = 4;
  localparam int PW = 8;
  localparam int CD = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic locked = 1'b0;
  logic sdram_rst, core_rst, cam_rst, ready;
  logic [7:0] lock_loss_cnt;
  int n_cmp = 0;
  int n_fail = 0;
  int age = 0;
  int m_llc = 0;
  logic hist [S];
  typedef struct {
    logic r;
    logic l;
    int   reps;
    logic sd;
    logic co;
    logic ca;
    logic rd;
    int   llc;
  } vec_t;
  vec_t tbl [16];
  sdram_pll_reset_seq #(
    .SYNC_STAGES(S), .LOCK_STABLE_CYC(LS), .SDRAM_PWRUP_CYC(PW), .CAM_DELAY_CYC(CD)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked), .sdram_rst(sdram_rst), .core_rst(core_rst),
    .cam_rst(cam_rst), .ready(ready), .lock_loss_cnt(lock_loss_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // age = consecutive edges that saw the synchronised lock high; every output is a threshold on it
  task automatic tick(input logic r, input logic l);
    logic ls;
    rst = r;
    locked = l;
    @(posedge clk);
    ls = hist[S-1];
    if (r) begin
      age = 0;
      m_llc = 0;
      for (int i = 0; i < S; i++) hist[i] = 1'b0;
    end else begin
      if (ls) age = (age < 100) ? age + 1 : age;
      else begin
        if (age > 0 && m_llc < 255) m_llc++;
        age = 0;
      end
      for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = l;
    end
    @(negedge clk);
    chk("m_sdram_rst", sdram_rst, age <= LS);
    chk("m_core_rst", core_rst, age <= LS + PW);
    chk("m_cam_rst", cam_rst, age <= LS + PW + CD);
    chk("m_ready", ready, age > LS + PW + CD);
    chk("m_lock_loss_cnt", lock_loss_cnt, m_llc);
    chk("order", (sdram_rst <= core_rst) && (core_rst <= cam_rst) && (ready == !cam_rst), 1);
  endtask
  initial begin
    int n;
    tbl[0]  = '{1'b1, 1'b1, 3, 1'b1, 1'b1, 1'b1, 1'b0, 0};
    tbl[1]  = '{1'b0, 1'b1, 6, 1'b1, 1'b1, 1'b1, 1'b0, 0};
    tbl[2]  = '{1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    tbl[3]  = '{1'b0, 1'b1, 7, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    tbl[4]  = '{1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[5]  = '{1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[6]  = '{1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[7]  = '{1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[8]  = '{1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[9]  = '{1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1};
    tbl[10] = '{1'b0, 1'b1, 4, 1'b1, 1'b1, 1'b1, 1'b0, 1};
    tbl[11] = '{1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    tbl[12] = '{1'b0, 1'b1, 7, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    tbl[13] = '{1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[14] = '{1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[15] = '{1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    for (int v = 0; v < 16; v++) begin
      for (int k = 0; k < tbl[v].reps; k++) tick(tbl[v].r, tbl[v].l);
      chk($sformatf("tbl%0d_sdram_rst", v), sdram_rst, tbl[v].sd);
      chk($sformatf("tbl%0d_core_rst", v), core_rst, tbl[v].co);
      chk($sformatf("tbl%0d_cam_rst", v), cam_rst, tbl[v].ca);
      chk($sformatf("tbl%0d_ready", v), ready, tbl[v].rd);
      chk($sformatf("tbl%0d_lock_loss_cnt", v), lock_loss_cnt, tbl[v].llc);
    end
    // lock drops for two cycles while STABLE counts, then returns
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    n = 0;
    do begin
      tick(1'b0, 1'b1);
      n++;
    end while (sdram_rst && n < 50);
    chk("stable_resync_sdram_edges", n, 7);
    chk("stable_resync_llc", lock_loss_cnt, 1);
    for (int k = 0; k < 8; k++) tick(1'b0, 1'b1);
    chk("stable_resync_core_rst", core_rst, 0);
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b1);
    chk("stable_resync_ready", ready, 1);
    // lock_s falls on the very edge PWRUP hits terminal count
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b1);
    for (int k = 0; k < 12; k++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    chk("tc_race_core_rst", core_rst, 1);
    chk("tc_race_sdram_rst", sdram_rst, 1);
    chk("tc_race_llc", lock_loss_cnt, 1);
    // saturation of the lock-loss counter
    for (int k = 0; k < 300; k++) begin
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
    end
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b0);
    chk("sat_llc", lock_loss_cnt, 255);
    tick(1'b1, 1'b1);
    chk("sat_rst_clear", lock_loss_cnt, 0);
    // random lock activity with occasional resets
    for (int k = 0; k < 150; k++) begin
      int hi = $urandom_range(1, 30);
      int lo = $urandom_range(1, 3);
      for (int j = 0; j < hi; j++) tick(($urandom_range(0, 199) == 0), 1'b1);
      for (int j = 0; j < lo; j++) tick(1'b0, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
